// File: rtl/collision_pkg.sv
// collision_pkg: shared types and default constants for the collision event
// generator and its per-character hit FSM.
package collision_pkg;

    // Per-character hit state: ALIVE accepts bubble hits, INVULN discards them.
    typedef enum logic {
        CHAR_ALIVE  = 1'b0,
        CHAR_INVULN = 1'b1
    } char_state_t;

    // Sticky per-frame event flags, one per collision source.
    typedef struct packed {
        logic bubble_char_1;
        logic bubble_char_2;
        logic arrow_1;
        logic arrow_2;
        logic life;
    } evt_flags_t;

    // Default configuration for lives and invulnerability.
    localparam int DEF_INIT_LIVES    = 3;
    localparam int DEF_MAX_LIVES     = 5;
    localparam int DEF_INVULN_FRAMES = 60;
    localparam int DEF_LIVES_W       = 3;

    // Number of accepted character hits in one frame evaluation (0..2).
    function automatic logic [1:0] hit_count(input logic hit_a, input logic hit_b);
        logic [1:0] sum;
        sum = {1'b0, hit_a} + {1'b0, hit_b};
        return sum;
    endfunction

endpackage

// File: rtl/char_hit_fsm.sv
// char_hit_fsm: per-character ALIVE/INVULN state machine.
// A hit seen at a frame evaluation while ALIVE (and not game over) produces a
// one-cycle charHit pulse and starts an invulnerability window measured in
// frames. The window counter decrements on every startOfFrame and the
// character returns to ALIVE once the count reaches zero.
module char_hit_fsm
    import collision_pkg::*;
#(
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic startOfFrame,
    input  logic hitFlag,
    input  logic gameOver,
    output logic charHit,
    output logic invuln
);

    // Window length held in the 8-bit frame counter (valid range 1..255).
    localparam logic [7:0] LOAD_FRAMES = 8'(INVULN_FRAMES);

    char_state_t state_r;
    logic [7:0]  frame_cnt_r;

    // State, frame counter and registered outputs; all change only at a frame boundary.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_r     <= CHAR_ALIVE;
            frame_cnt_r <= 8'd0;
            charHit     <= 1'b0;
            invuln      <= 1'b0;
        end else begin
            charHit <= 1'b0;
            if (startOfFrame) begin
                case (state_r)
                    CHAR_ALIVE: begin
                        if (hitFlag && !gameOver) begin
                            state_r     <= CHAR_INVULN;
                            frame_cnt_r <= LOAD_FRAMES;
                            charHit     <= 1'b1;
                            invuln      <= 1'b1;
                        end else begin
                            frame_cnt_r <= 8'd0;
                            invuln      <= 1'b0;
                        end
                    end
                    CHAR_INVULN: begin
                        // Hits are ignored here; only the window runs down.
                        if (frame_cnt_r <= 8'd1) begin
                            state_r     <= CHAR_ALIVE;
                            frame_cnt_r <= 8'd0;
                            invuln      <= 1'b0;
                        end else begin
                            frame_cnt_r <= frame_cnt_r - 8'd1;
                            invuln      <= 1'b1;
                        end
                    end
                    default: begin
                        state_r     <= CHAR_ALIVE;
                        frame_cnt_r <= 8'd0;
                        invuln      <= 1'b0;
                    end
                endcase
            end else begin
                state_r     <= state_r;
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

endmodule

// File: rtl/collision_event_gen.sv
// collision_event_gen: folds per-pixel collision flags into at most one event
// per source per video frame, runs per-character invulnerability and a shared
// saturating lives counter with a sticky game-over flag.
// Optional feature macro: SECOND_PLAYER_EN (defined = two characters; left
// undefined = character 2 inputs ignored and its outputs tied low).
module collision_event_gen
    import collision_pkg::*;
#(
    parameter int INIT_LIVES    = DEF_INIT_LIVES,
    parameter int MAX_LIVES     = DEF_MAX_LIVES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    // Must satisfy 2**LIVES_W > MAX_LIVES.
    parameter int LIVES_W       = DEF_LIVES_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               restart,
    input  logic               bubbleHitChar_1,
    input  logic               bubbleHitChar_2,
    input  logic               arrow_1_HitBubble,
    input  logic               arrow_2_HitBubble,
    input  logic               lifeHitChar,
    output logic               charHit_1,
    output logic               charHit_2,
    output logic               arrowPop_1,
    output logic               arrowPop_2,
    output logic               lifeCollected,
    output logic               invuln_1,
    output logic               invuln_2,
    output logic [LIVES_W-1:0] lives,
    output logic               gameOver
);

    localparam logic [LIVES_W-1:0]        INIT_L = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0]        MAX_L  = LIVES_W'(MAX_LIVES);
    localparam logic signed [LIVES_W+1:0] MAX_S  = (LIVES_W+2)'(MAX_LIVES);

    evt_flags_t                pix_s;
    evt_flags_t                flags_r;
    logic                      hit_acc_1_s;
    logic                      hit_acc_2_s;
    logic                      life_acc_s;
    logic [1:0]                hits_s;
    logic signed [LIVES_W+1:0] lives_ext_s;
    logic signed [LIVES_W+1:0] next_raw_s;
    logic [LIVES_W-1:0]        next_lives_s;

    // Map the raw per-pixel inputs onto the event struct; absent sources read as 0.
    always_comb begin
        pix_s               = '0;
        pix_s.bubble_char_1 = bubbleHitChar_1;
        pix_s.arrow_1       = arrow_1_HitBubble;
        pix_s.life          = lifeHitChar;
`ifdef SECOND_PLAYER_EN
        pix_s.bubble_char_2 = bubbleHitChar_2;
        pix_s.arrow_2       = arrow_2_HitBubble;
`endif
    end

`ifndef SECOND_PLAYER_EN
    // Character 2 inputs have no effect in the single-player build.
    logic unused_char2_s;
    assign unused_char2_s = bubbleHitChar_2 ^ arrow_2_HitBubble;
`endif

    // Sticky accumulation: a startOfFrame cycle restarts the flags with that cycle's pixels.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            flags_r <= '0;
        end else if (startOfFrame) begin
            flags_r <= pix_s;
        end else begin
            flags_r <= evt_flags_t'(flags_r | pix_s);
        end
    end

    // Hits and pickups accepted at this frame evaluation (mirrors the FSM accept rule).
    always_comb begin
        hit_acc_1_s = startOfFrame && flags_r.bubble_char_1 && !invuln_1 && !gameOver;
`ifdef SECOND_PLAYER_EN
        hit_acc_2_s = startOfFrame && flags_r.bubble_char_2 && !invuln_2 && !gameOver;
`else
        hit_acc_2_s = 1'b0;
`endif
        life_acc_s  = startOfFrame && flags_r.life && !gameOver;
    end

    // Next lives value: signed net change, then clamp to [0, MAX_LIVES].
    always_comb begin
        hits_s      = hit_count(hit_acc_1_s, hit_acc_2_s);
        lives_ext_s = $signed({2'b00, lives});
        next_raw_s  = lives_ext_s
                    - $signed({{LIVES_W{1'b0}}, hits_s})
                    + $signed({{(LIVES_W+1){1'b0}}, life_acc_s});
        if (next_raw_s[LIVES_W+1]) begin
            next_lives_s = '0;
        end else if (next_raw_s > MAX_S) begin
            next_lives_s = MAX_L;
        end else begin
            next_lives_s = next_raw_s[LIVES_W-1:0];
        end
    end

    // Registered event pulses, lives register and sticky game-over.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            lives         <= INIT_L;
            gameOver      <= 1'b0;
            lifeCollected <= 1'b0;
            arrowPop_1    <= 1'b0;
        end else begin
            // Arrow pops are reported even after game over.
            arrowPop_1    <= startOfFrame && flags_r.arrow_1;
            lifeCollected <= life_acc_s;
            if (startOfFrame) begin
                lives <= next_lives_s;
                if (next_lives_s == '0) begin
                    gameOver <= 1'b1;
                end else begin
                    gameOver <= gameOver;
                end
            end else begin
                lives <= lives;
            end
        end
    end

    char_hit_fsm #(
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_char_1 (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .startOfFrame (startOfFrame),
        .hitFlag      (flags_r.bubble_char_1),
        .gameOver     (gameOver),
        .charHit      (charHit_1),
        .invuln       (invuln_1)
    );

`ifdef SECOND_PLAYER_EN
    char_hit_fsm #(
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_char_2 (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .startOfFrame (startOfFrame),
        .hitFlag      (flags_r.bubble_char_2),
        .gameOver     (gameOver),
        .charHit      (charHit_2),
        .invuln       (invuln_2)
    );

    // Arrow 2 pop pulse, registered like arrow 1.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            arrowPop_2 <= 1'b0;
        end else begin
            arrowPop_2 <= startOfFrame && flags_r.arrow_2;
        end
    end
`else
    assign charHit_2  = 1'b0;
    assign invuln_2   = 1'b0;
    assign arrowPop_2 = 1'b0;
`endif

endmodule

// File: tb/tb_collision_event_gen.sv
// tb_collision_event_gen: directed stimulus, an integer-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_collision_event_gen;

`ifdef SECOND_PLAYER_EN
    localparam bit SP = 1'b1;
`else
    localparam bit SP = 1'b0;
`endif
    localparam int INIT = 3;
    localparam int MAXL = 5;
    localparam int INV  = 60;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, restart;
    logic       bubbleHitChar_1, bubbleHitChar_2;
    logic       arrow_1_HitBubble, arrow_2_HitBubble, lifeHitChar;
    logic       charHit_1, charHit_2, arrowPop_1, arrowPop_2, lifeCollected;
    logic       invuln_1, invuln_2, gameOver;
    logic [2:0] lives;

    int compared = 0;
    int failed   = 0;

    collision_event_gen dut (
        .clk               (clk),
        .reset             (reset),
        .startOfFrame      (startOfFrame),
        .restart           (restart),
        .bubbleHitChar_1   (bubbleHitChar_1),
        .bubbleHitChar_2   (bubbleHitChar_2),
        .arrow_1_HitBubble (arrow_1_HitBubble),
        .arrow_2_HitBubble (arrow_2_HitBubble),
        .lifeHitChar       (lifeHitChar),
        .charHit_1         (charHit_1),
        .charHit_2         (charHit_2),
        .arrowPop_1        (arrowPop_1),
        .arrowPop_2        (arrowPop_2),
        .lifeCollected     (lifeCollected),
        .invuln_1          (invuln_1),
        .invuln_2          (invuln_2),
        .lives             (lives),
        .gameOver          (gameOver)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (integer level) ----------------
    bit f_b1, f_b2, f_a1, f_a2, f_l;
    int m_lives, m_cnt1, m_cnt2, nl_m;
    bit m_go;
    bit e_ch1, e_ch2, e_p1, e_p2, e_lc;
    bit a1_m, a2_m, lc_m;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset || restart) begin
            {f_b1, f_b2, f_a1, f_a2, f_l} = 5'b0;
            {e_ch1, e_ch2, e_p1, e_p2, e_lc} = 5'b0;
            m_lives = INIT; m_go = 1'b0; m_cnt1 = 0; m_cnt2 = 0;
            model_valid = 1'b1;
        end else if (startOfFrame) begin
            a1_m = f_b1 && (m_cnt1 == 0) && !m_go;
            a2_m = SP && f_b2 && (m_cnt2 == 0) && !m_go;
            lc_m = f_l && !m_go;
            e_ch1 = a1_m; e_ch2 = a2_m; e_lc = lc_m;
            e_p1 = f_a1; e_p2 = SP && f_a2;
            if (a1_m) m_cnt1 = INV; else if (m_cnt1 > 0) m_cnt1 = m_cnt1 - 1;
            if (a2_m) m_cnt2 = INV; else if (m_cnt2 > 0) m_cnt2 = m_cnt2 - 1;
            nl_m = m_lives - int'(a1_m) - int'(a2_m) + int'(lc_m);
            if (nl_m < 0) nl_m = 0;
            if (nl_m > MAXL) nl_m = MAXL;
            m_lives = nl_m;
            if (nl_m == 0) m_go = 1'b1;
            f_b1 = bubbleHitChar_1; f_b2 = SP && bubbleHitChar_2;
            f_a1 = arrow_1_HitBubble; f_a2 = SP && arrow_2_HitBubble;
            f_l  = lifeHitChar;
        end else begin
            {e_ch1, e_ch2, e_p1, e_p2, e_lc} = 5'b0;
            f_b1 = f_b1 | bubbleHitChar_1; f_b2 = f_b2 | (SP && bubbleHitChar_2);
            f_a1 = f_a1 | arrow_1_HitBubble; f_a2 = f_a2 | (SP && arrow_2_HitBubble);
            f_l  = f_l | lifeHitChar;
        end
    end

    // Per-cycle comparison of every output against the model.
    logic [10:0] act_v, exp_v;
    always @(negedge clk) begin
        if (model_valid) begin
            act_v = {charHit_1, charHit_2, arrowPop_1, arrowPop_2, lifeCollected,
                     invuln_1, invuln_2, lives, gameOver};
            exp_v = {e_ch1, e_ch2, e_p1, e_p2, e_lc, (m_cnt1 > 0), (m_cnt2 > 0),
                     3'(m_lives), m_go};
            compared++;
            if (act_v !== exp_v) begin
                failed++;
                $display("FAIL model_cmp t=%0t {ch1,ch2,pop1,pop2,lc,inv1,inv2,lives[3],go} got=%b want=%b",
                         $time, act_v, exp_v);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        repeat (n) begin
            idle(2);
            pulse_sof();
        end
    endtask

    task automatic hit1_frame();
        bubbleHitChar_1 = 1'b1;
        idle(2);
        bubbleHitChar_1 = 1'b0;
        idle(1);
        pulse_sof();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; restart = 1'b0; startOfFrame = 1'b0;
        bubbleHitChar_1 = 1'b0; bubbleHitChar_2 = 1'b0;
        arrow_1_HitBubble = 1'b0; arrow_2_HitBubble = 1'b0; lifeHitChar = 1'b0;
        idle(2);
        reset = 1'b0;
        chk("reset_lives", 32'(lives), 32'd3);
        chk("reset_gameover", 32'(gameOver), 32'd0);
        chk("reset_invuln_1", 32'(invuln_1), 32'd0);
        idle(3);

        // Coincidence: pulses during the startOfFrame cycle belong to the new frame.
        startOfFrame = 1'b1; bubbleHitChar_2 = 1'b1; arrow_1_HitBubble = 1'b1;
        tick();
        startOfFrame = 1'b0; bubbleHitChar_2 = 1'b0; arrow_1_HitBubble = 1'b0;
        chk("coinc_no_ch2", 32'(charHit_2), 32'd0);
        chk("coinc_no_pop1", 32'(arrowPop_1), 32'd0);
        arrow_2_HitBubble = 1'b1;
        idle(2);
        arrow_2_HitBubble = 1'b0;
        idle(2);
        pulse_sof();
        chk("coinc_ch2_next", 32'(charHit_2), 32'(SP));
        chk("coinc_pop1_next", 32'(arrowPop_1), 32'd1);
        chk("coinc_pop2", 32'(arrowPop_2), 32'(SP));
        chk("coinc_lives", 32'(lives), SP ? 32'd2 : 32'd3);
        tick();
        chk("pop1_one_cycle", 32'(arrowPop_1), 32'd0);
        do_restart();
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_invuln_2", 32'(invuln_2), 32'd0);

        // Single hit: 40 cycles of overlap fold into one event.
        idle(2);
        bubbleHitChar_1 = 1'b1;
        idle(40);
        bubbleHitChar_1 = 1'b0;
        idle(3);
        pulse_sof();
        chk("hit_ch1", 32'(charHit_1), 32'd1);
        chk("hit_lives", 32'(lives), 32'd2);
        chk("hit_invuln", 32'(invuln_1), 32'd1);
        tick();
        chk("hit_pulse_width", 32'(charHit_1), 32'd0);

        // Invulnerability window: 59 frames of hits are discarded.
        for (int i = 0; i < 59; i++) begin
            bubbleHitChar_1 = 1'b1;
            idle(3);
            bubbleHitChar_1 = 1'b0;
            idle(2);
            pulse_sof();
            chk("inv_no_hit", 32'(charHit_1), 32'd0);
            chk("inv_lives", 32'(lives), 32'd2);
        end
        chk("inv_still_set_59", 32'(invuln_1), 32'd1);
        idle(3);
        pulse_sof();
        chk("inv_drop_60", 32'(invuln_1), 32'd0);
        hit1_frame();
        chk("inv_after_hit", 32'(charHit_1), 32'd1);
        chk("inv_after_lives", 32'(lives), 32'd1);

        // Saturation: climb to MAX_LIVES, then one more pickup.
        for (int i = 0; i < 4; i++) begin
            lifeHitChar = 1'b1;
            idle(2);
            lifeHitChar = 1'b0;
            pulse_sof();
            chk("life_pulse", 32'(lifeCollected), 32'd1);
            chk("life_lives", 32'(lives), 32'(2 + i));
        end
        lifeHitChar = 1'b1;
        idle(2);
        lifeHitChar = 1'b0;
        pulse_sof();
        chk("sat_pulse", 32'(lifeCollected), 32'd1);
        chk("sat_lives", 32'(lives), 32'd5);
        do_restart();
        chk("restart2_lives", 32'(lives), 32'd3);

        // Bring lives to 1 with both characters ALIVE.
        hit1_frame();
        chk("net_prep_2", 32'(lives), 32'd2);
        wait_frames(60);
        hit1_frame();
        chk("net_prep_1", 32'(lives), 32'd1);
        wait_frames(60);
        chk("net_prep_alive", 32'(invuln_1), 32'd0);

        // Net arithmetic: both hits plus a life token in one frame.
        bubbleHitChar_1 = 1'b1; bubbleHitChar_2 = 1'b1; lifeHitChar = 1'b1; arrow_1_HitBubble = 1'b1;
        idle(5);
        bubbleHitChar_1 = 1'b0; bubbleHitChar_2 = 1'b0; lifeHitChar = 1'b0; arrow_1_HitBubble = 1'b0;
        pulse_sof();
        chk("net_lc", 32'(lifeCollected), 32'd1);
        chk("net_ch1", 32'(charHit_1), 32'd1);
        chk("net_ch2", 32'(charHit_2), 32'(SP));
        chk("net_lives", 32'(lives), SP ? 32'd0 : 32'd1);
        chk("net_gameover", 32'(gameOver), 32'(SP));

        // Following frame: hits suppressed, arrow pop still reported.
        bubbleHitChar_1 = 1'b1; bubbleHitChar_2 = 1'b1; arrow_1_HitBubble = 1'b1;
        idle(3);
        bubbleHitChar_1 = 1'b0; bubbleHitChar_2 = 1'b0; arrow_1_HitBubble = 1'b0;
        pulse_sof();
        chk("post_ch1", 32'(charHit_1), 32'd0);
        chk("post_ch2", 32'(charHit_2), 32'd0);
        chk("post_pop1", 32'(arrowPop_1), 32'd1);
        chk("post_lives", 32'(lives), SP ? 32'd0 : 32'd1);

        // Drive to game over in either build.
        wait_frames(60);
        hit1_frame();
        chk("go_ch1", 32'(charHit_1), SP ? 32'd0 : 32'd1);
        chk("go_lives", 32'(lives), 32'd0);
        chk("go_set", 32'(gameOver), 32'd1);

        // Restart mid-frame with flags set and game over.
        bubbleHitChar_1 = 1'b1; arrow_1_HitBubble = 1'b1; lifeHitChar = 1'b1;
        idle(3);
        bubbleHitChar_1 = 1'b0; arrow_1_HitBubble = 1'b0; lifeHitChar = 1'b0;
        do_restart();
        chk("rst_mid_lives", 32'(lives), 32'd3);
        chk("rst_mid_go", 32'(gameOver), 32'd0);
        chk("rst_mid_inv1", 32'(invuln_1), 32'd0);
        chk("rst_mid_inv2", 32'(invuln_2), 32'd0);
        idle(3);
        pulse_sof();
        chk("rst_mid_no_ch1", 32'(charHit_1), 32'd0);
        chk("rst_mid_no_pop1", 32'(arrowPop_1), 32'd0);
        chk("rst_mid_no_lc", 32'(lifeCollected), 32'd0);
        chk("rst_mid_lives2", 32'(lives), 32'd3);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
